if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Pipeline register between the fetch stage and decode.
- Latches the fetched instruction, PC_curr and PC_Next every cycle, with hazard-unit stall and execute-stage flush.
- Detects HALT in the IF/ID slot, holds fetch via fetch_hold (drives fetch's NOP input), then drains the pipe and asserts halted.
- Also keeps a saturating bubble counter for performance debug.

Parameters:
- WIDTH, 16, instruction and PC width.
- NOP_INSTR, 16'h0800, encoding inserted as a bubble.
- HALT_OPCODE, 5'b00000, instr[15:11] value identifying HALT.
- HALT_DRAIN, 3, cycles after HALT leaves IF/ID before halted asserts (range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- instr_in  in  WIDTH  instruction from fetch.
- pc_curr_in  in  WIDTH  PC of the fetched instruction.
- pc_next_in  in  WIDTH  PC+2 / held PC from fetch.
- stall  in  1  hazard unit: hold IF/ID contents.
- flush  in  1  execute stage, taken branch/jump: kill the IF/ID contents.
- instr_out  out  WIDTH  instruction to decode.
- pc_curr_out  out  WIDTH  registered PC_curr.
- pc_next_out  out  WIDTH  registered PC_Next.
- valid_out  out  1  1 = instr_out is a real instruction, 0 = bubble.
- fetch_hold  out  1  to fetch: freeze PC (high in HALT_PEND and HALTED).
- halted  out  1  pipeline drained after HALT; sticky until reset.
- bubble_cnt  out  16  count of bubbles inserted; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, async):
  - instr_out=NOP_INSTR; pc_curr_out=pc_next_out=0; valid_out=0.
  - State RUN; drain_cnt=0; halt_in_reg=0; bubble_cnt=0.
  - fetch_hold=0; halted=0.
  - Deassertion is synchronous to clk via the existing flop style; no output changes until the first edge after release.
- Register update per rising edge, priority flush > stall > load:
  - flush: instr_out<=NOP_INSTR, valid_out<=0; PC outputs hold; bubble_cnt+1.
  - stall (no flush): all IF/ID fields hold; bubble_cnt unchanged.
  - load in RUN: capture instr_in, pc_curr_in, pc_next_in; valid_out<=1.
  - load in HALT_PEND or HALTED: instr_out<=NOP_INSTR, valid_out<=0, PCs captured, bubble_cnt+1 (squash).
- Latency: 1 cycle input->output. Outputs are purely registered, except fetch_hold/halted, which decode the state register.
- HALT detect: a load in RUN with instr_in[15:11]==HALT_OPCODE, no flush and no stall gives:
  - next state HALT_PEND;
  - halt_in_reg<=1;
  - HALT itself captured with valid_out=1.
- FSM (state register, 2 bits):
  - RUN: fetch_hold=0. Goes to HALT_PEND on HALT detect.
  - HALT_PEND: fetch_hold=1.
    - flush while halt_in_reg=1 -> RUN, halt_in_reg<=0 (HALT was wrong-path).
    - Any edge with halt_in_reg=1, no stall and no flush -> halt_in_reg<=0 (HALT advanced), drain_cnt<=0.
    - While halt_in_reg=0: drain_cnt increments each edge. When drain_cnt==HALT_DRAIN-1 -> HALTED.
    - flush is ignored once halt_in_reg=0.
  - HALTED: terminal; fetch_hold=1, halted=1; IF/ID loads bubbles only, but the bubble counter freezes. Left only by reset.
- bubble_cnt: saturating. Never wraps; no increment in HALTED.
- Stall and flush in the same cycle: flush wins, including cancellation of a pending HALT.
- Reset mid-HALT_PEND or in HALTED: returns to RUN with reset values above.
- Width rules: no arithmetic on PCs; they pass through unmodified.

Decomposition:
- Shared package (isa_pkg): NOP_INSTR, HALT_OPCODE, and opcode field slice constants [15:11]. State encoding RUN=2'b00, HALT_PEND=2'b01, HALTED=2'b10; 2'b11 is illegal and recovers to RUN.
- One sub-module, halt_ctrl:
  - contents: the FSM, drain_cnt and halt_in_reg;
  - inputs: load, flush, stall, is_halt;
  - outputs: state, fetch_hold, halted, squash.
- if_id_stage keeps the data registers and bubble_cnt.

Test Plan:
- Reset: drive instr_in=16'h4001, then rst=0 mid-cycle -> outputs immediately instr_out=16'h0800, valid_out=0, PCs=0, fetch_hold=0, halted=0, bubble_cnt=0.
- Stream: instr_in=16'h4001, pc_curr_in=16'h0010, pc_next_in=16'h0012 -> after 1 edge outputs equal inputs, valid_out=1. Next edge with 16'h4802/0012/0014 tracks.
- Stall then flush+stall: stall=1 two edges -> outputs frozen at 16'h4001. Then flush=1 with stall=1 -> instr_out=16'h0800, valid_out=0, bubble_cnt=1.
- Halt: load instr_in=16'h0000 -> fetch_hold=1 after the edge. Next edge: squash gives valid_out=0. With HALT_DRAIN=3, halted=1 exactly 4 edges after the HALT capture. Further edges leave bubble_cnt fixed.
- Halt cancel: HALT captured, then flush=1 on the next edge -> state RUN, fetch_hold=0, instr_out=16'h0800. A subsequent 16'h4001 loads with valid_out=1.
- Halt under stall: HALT captured, stall=1 for 2 edges -> halted stays 0, drain not started. After release, halted=1 after 1+3 further edges. Also check that bubble_cnt saturates: preload via 65536 flushes -> stays 16'hFFFF.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants and the HALT controller state encoding for the IF/ID stage.
package isa_pkg;

    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam int          OPC_MSB     = 15;
    localparam int          OPC_LSB     = 11;

    // 2'b11 is unused and recovers to ST_RUN
    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_HALT_PEND = 2'b01,
        ST_HALTED    = 2'b10
    } state_e;

endpackage

// File: rtl/halt_ctrl.sv
// HALT sequencing: holds fetch once a HALT sits in IF/ID, waits for it to move on,
// drains the pipe for HALT_DRAIN cycles, then parks in HALTED until reset.
module halt_ctrl import isa_pkg::*; #(
    parameter int HALT_DRAIN = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  logic   stall,
    input  logic   is_halt,
    output state_e state,
    output logic   fetch_hold,
    output logic   halted,
    output logic   squash
);

    localparam logic [3:0] DRAIN_LAST = 4'(HALT_DRAIN - 1);

    state_e     r_state;
    logic [3:0] r_drain_cnt;
    logic       r_halt_in_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= '0;
            r_halt_in_reg <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (load && is_halt) begin
                        r_state       <= ST_HALT_PEND;
                        r_halt_in_reg <= 1'b1;
                    end
                end
                ST_HALT_PEND: begin
                    // While the HALT is still in IF/ID a flush means it was wrong-path
                    if (r_halt_in_reg) begin
                        if (flush) begin
                            r_state       <= ST_RUN;
                            r_halt_in_reg <= 1'b0;
                        end else if (!stall) begin
                            r_halt_in_reg <= 1'b0;
                            r_drain_cnt   <= '0;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 4'd1;
                        if (r_drain_cnt == DRAIN_LAST)
                            r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default: begin
                    r_state       <= ST_RUN;
                    r_halt_in_reg <= 1'b0;
                end
            endcase
        end
    end

    assign state      = r_state;
    assign fetch_hold = (r_state == ST_HALT_PEND) || (r_state == ST_HALTED);
    assign halted     = (r_state == ST_HALTED);
    assign squash     = fetch_hold;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall/flush, HALT squashing via halt_ctrl,
// and a saturating bubble counter for performance debug.
module if_id_stage #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] NOP_INSTR   = isa_pkg::NOP_INSTR,
    parameter logic [4:0]       HALT_OPCODE = isa_pkg::HALT_OPCODE,
    parameter int               HALT_DRAIN  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_curr_in,
    input  logic [WIDTH-1:0] pc_next_in,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_curr_out,
    output logic [WIDTH-1:0] pc_next_out,
    output logic             valid_out,
    output logic             fetch_hold,
    output logic             halted,
    output logic [15:0]      bubble_cnt
);

    logic [WIDTH-1:0] r_instr, r_pc_curr, r_pc_next;
    logic             r_valid;
    logic [15:0]      r_bubble_cnt;

    isa_pkg::state_e  w_state;
    logic             w_load, w_is_halt, w_squash, w_count;

    assign w_load    = !flush && !stall;
    assign w_is_halt = (instr_in[isa_pkg::OPC_MSB:isa_pkg::OPC_LSB] == HALT_OPCODE);

    halt_ctrl #(.HALT_DRAIN(HALT_DRAIN)) u_halt_ctrl (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .flush      (flush),
        .stall      (stall),
        .is_halt    (w_is_halt),
        .state      (w_state),
        .fetch_hold (fetch_hold),
        .halted     (halted),
        .squash     (w_squash)
    );

    // Bubbles still enter IF/ID once HALTED, they just stop being counted
    assign w_count = (flush || (w_load && w_squash)) && (w_state != isa_pkg::ST_HALTED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr   <= NOP_INSTR;
            r_pc_curr <= '0;
            r_pc_next <= '0;
            r_valid   <= 1'b0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_pc_curr <= pc_curr_in;
            r_pc_next <= pc_next_in;
            r_instr   <= w_squash ? NOP_INSTR : instr_in;
            r_valid   <= !w_squash;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_bubble_cnt <= '0;
        else if (w_count && (r_bubble_cnt != 16'hFFFF))
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end

    assign instr_out   = r_instr;
    assign pc_curr_out = r_pc_curr;
    assign pc_next_out = r_pc_next;
    assign valid_out   = r_valid;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus a randomized run
// against a cycle-level reference model of the IF/ID + HALT behaviour.
module tb_if_id_stage;

    logic        clk, rst, stall, flush;
    logic [15:0] instr_in, pc_curr_in, pc_next_in;
    logic [15:0] instr_out, pc_curr_out, pc_next_out, bubble_cnt;
    logic        valid_out, fetch_hold, halted;

    int errors = 0;
    int checks = 0;

    if_id_stage #(.WIDTH(16), .NOP_INSTR(16'h0800), .HALT_OPCODE(5'b00000), .HALT_DRAIN(3)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_curr_in(pc_curr_in),
        .pc_next_in(pc_next_in), .stall(stall), .flush(flush),
        .instr_out(instr_out), .pc_curr_out(pc_curr_out), .pc_next_out(pc_next_out),
        .valid_out(valid_out), .fetch_hold(fetch_hold), .halted(halted),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. m_mode: 0 running, 1 HALT sitting in IF/ID,
    // 2 HALT gone and pipe draining, 3 halted for good.
    logic [15:0] m_instr, m_pcc, m_pcn, m_bub;
    logic        m_valid;
    int          m_mode, m_drain;

    function automatic void m_reset();
        m_instr = 16'h0800; m_pcc = 0; m_pcn = 0; m_valid = 0; m_bub = 0;
        m_mode = 0; m_drain = 0;
    endfunction

    function automatic void m_bubble();
        if (m_mode != 3 && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
    endfunction

    function automatic void m_edge();
        logic [15:0] ins;
        ins = instr_in;
        if (flush) begin
            m_instr = 16'h0800; m_valid = 0; m_bubble();
        end else if (!stall) begin
            m_pcc = pc_curr_in; m_pcn = pc_next_in;
            if (m_mode != 0) begin
                m_instr = 16'h0800; m_valid = 0; m_bubble();
            end else begin
                m_instr = ins; m_valid = 1;
            end
        end
        case (m_mode)
            0: if (!flush && !stall && ins[15:11] == 5'd0) m_mode = 1;
            1: if (flush) m_mode = 0; else if (!stall) begin m_mode = 2; m_drain = 0; end
            2: begin m_drain++; if (m_drain == 3) m_mode = 3; end
            default: ;
        endcase
    endfunction

    function automatic logic [66:0] m_vec();
        return {m_instr, m_pcc, m_pcn, m_valid, 1'(m_mode != 0), 1'(m_mode == 3), m_bub};
    endfunction

    logic [66:0] dut_vec;
    assign dut_vec = {instr_out, pc_curr_out, pc_next_out, valid_out, fetch_hold, halted, bubble_cnt};

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; m_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; instr_in = 16'h4001; pc_curr_in = 16'h0010; pc_next_in = 16'h0012;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0; m_reset();
        #12 rst = 1'b1;
        step();
        #2 rst = 1'b0; m_reset();
        #1;
        checks++;
        if (dut_vec !== {16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL reset_async got %h want %h", dut_vec, {16'h0800, 32'h0, 3'b0, 16'h0});
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_stream();
        instr_in = 16'h4001; pc_curr_in = 16'h0010; pc_next_in = 16'h0012;
        step();
        checks++;
        if ({instr_out, pc_curr_out, pc_next_out, valid_out} !== {16'h4001, 16'h0010, 16'h0012, 1'b1}) begin
            errors++; $display("FAIL stream_first got %h want %h", {instr_out, pc_curr_out, pc_next_out, valid_out}, {16'h4001, 16'h0010, 16'h0012, 1'b1});
        end
        instr_in = 16'h4802; pc_curr_in = 16'h0012; pc_next_in = 16'h0014;
        step();
        checks++;
        if ({instr_out, pc_curr_out, pc_next_out, valid_out} !== {16'h4802, 16'h0012, 16'h0014, 1'b1}) begin
            errors++; $display("FAIL stream_second got %h want %h", {instr_out, pc_curr_out, pc_next_out, valid_out}, {16'h4802, 16'h0012, 16'h0014, 1'b1});
        end
    endtask

    task automatic test_stall_flush();
        instr_in = 16'h4001; pc_curr_in = 16'h0010; pc_next_in = 16'h0012;
        step();
        stall = 1; instr_in = 16'h5555; pc_curr_in = 16'h0100; pc_next_in = 16'h0102;
        step(); step();
        checks++;
        if ({instr_out, pc_curr_out, valid_out, bubble_cnt} !== {16'h4001, 16'h0010, 1'b1, 16'd0}) begin
            errors++; $display("FAIL stall_hold got %h want %h", {instr_out, pc_curr_out, valid_out, bubble_cnt}, {16'h4001, 16'h0010, 1'b1, 16'd0});
        end
        flush = 1;
        step();
        checks++;
        if ({instr_out, pc_curr_out, pc_next_out, valid_out, bubble_cnt} !== {16'h0800, 16'h0010, 16'h0012, 1'b0, 16'd1}) begin
            errors++; $display("FAIL flush_over_stall got %h want %h", {instr_out, pc_curr_out, pc_next_out, valid_out, bubble_cnt}, {16'h0800, 16'h0010, 16'h0012, 1'b0, 16'd1});
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        do_reset(); idle_inputs();
        instr_in = 16'h0000; pc_curr_in = 16'h0020; pc_next_in = 16'h0022;
        step();
        checks++;
        if ({fetch_hold, valid_out, instr_out, halted} !== {1'b1, 1'b1, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL halt_capture got %h want %h", {fetch_hold, valid_out, instr_out, halted}, {1'b1, 1'b1, 16'h0000, 1'b0});
        end
        instr_in = 16'h4802; pc_curr_in = 16'h0022; pc_next_in = 16'h0022;
        step();
        checks++;
        if ({valid_out, instr_out, pc_curr_out} !== {1'b0, 16'h0800, 16'h0022}) begin
            errors++; $display("FAIL halt_squash got %h want %h", {valid_out, instr_out, pc_curr_out}, {1'b0, 16'h0800, 16'h0022});
        end
        step(); step();
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b want 0", halted); end
        step();
        checks++;
        if ({halted, fetch_hold, bubble_cnt} !== {1'b1, 1'b1, 16'd4}) begin
            errors++; $display("FAIL halt_done got %h want %h", {halted, fetch_hold, bubble_cnt}, {1'b1, 1'b1, 16'd4});
        end
        flush = 1; step(); flush = 0; step(); step();
        checks++;
        if ({halted, valid_out, bubble_cnt} !== {1'b1, 1'b0, 16'd4} || dut_vec !== m_vec()) begin
            errors++; $display("FAIL halt_frozen got %h want %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_halt_cancel();
        do_reset(); idle_inputs();
        instr_in = 16'h0000;
        step();
        flush = 1; instr_in = 16'h4001;
        step();
        checks++;
        if ({fetch_hold, instr_out, valid_out} !== {1'b0, 16'h0800, 1'b0}) begin
            errors++; $display("FAIL cancel_flush got %h want %h", {fetch_hold, instr_out, valid_out}, {1'b0, 16'h0800, 1'b0});
        end
        flush = 0;
        step();
        checks++;
        if ({instr_out, valid_out, fetch_hold} !== {16'h4001, 1'b1, 1'b0} || dut_vec !== m_vec()) begin
            errors++; $display("FAIL cancel_reload got %h want %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_halt_stall();
        do_reset(); idle_inputs();
        instr_in = 16'h0000;
        step();
        stall = 1; instr_in = 16'h4001;
        step(); step();
        checks++;
        if ({halted, fetch_hold, instr_out, valid_out} !== {1'b0, 1'b1, 16'h0000, 1'b1}) begin
            errors++; $display("FAIL halt_stall_hold got %h want %h", {halted, fetch_hold, instr_out, valid_out}, {1'b0, 1'b1, 16'h0000, 1'b1});
        end
        stall = 0;
        step(); step(); step();
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL halt_stall_early got %b want 0", halted); end
        step();
        checks++;
        if (halted !== 1'b1 || dut_vec !== m_vec()) begin
            errors++; $display("FAIL halt_stall_done got %h want %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_random();
        do_reset(); idle_inputs();
        for (int n = 0; n < 500; n++) begin
            if (m_mode == 3 && $urandom_range(0, 7) == 0) do_reset();
            flush      = ($urandom_range(0, 7) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            instr_in   = ($urandom_range(0, 11) == 0) ? 16'(($urandom & 16'h07FF)) : 16'($urandom);
            pc_curr_in = 16'($urandom);
            pc_next_in = 16'($urandom);
            step();
            checks++;
            if (dut_vec !== m_vec()) begin
                errors++; $display("FAIL random_%0d got %h want %h", n, dut_vec, m_vec());
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        do_reset(); idle_inputs();
        flush = 1;
        repeat (65535) step();
        checks++;
        if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", bubble_cnt); end
        step();
        checks++;
        if (bubble_cnt !== 16'hFFFF || dut_vec !== m_vec()) begin
            errors++; $display("FAIL sat_hold got %h want %h", dut_vec, m_vec());
        end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_flush();
        test_halt();
        test_halt_cancel();
        test_halt_stall();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
